mc_main_fsm: RTL and testbench

//  Main control FSM of the multi-cycle RISC-V core; sequences FETCH..WRITEBACK for RV32I subset lw/sw/R/I-ALU/beq/jal.

---
 rtl/mc_main_fsm_if.sv | 29 ++
 rtl/mc_main_fsm.sv | 158 +++++++++++++++
 tb/tb_mc_main_fsm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mc_main_fsm_if.sv
// Control bundle between the main FSM and the multi-cycle datapath.
// Master is the FSM; slave is the datapath/memory side.
interface mc_main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, state
  );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core (lw/sw/R/I-ALU/beq/jal).
// Datapath controls are decoded from the state register; strobes wait on mem_ready.
module mc_main_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mc_main_fsm_if.master   bus
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic       rdy;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       adr_src_d;
  logic [1:0] result_src_d;
  logic [1:0] alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;

  assign rdy = bus.mem_ready | ~USE_MEM_READY;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src_d     = 1'b0;
    result_src_d  = 2'b00;
    alu_src_a_d   = 2'b00;
    alu_src_b_d   = 2'b00;
    alu_op_d      = 2'b00;

    case (state_q)
      S_FETCH: begin
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
        ir_write_raw = rdy;
        pc_update    = rdy;
        state_d      = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here so BEQ can use ALUOut
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_d = 1'b1;
        state_d   = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_d  = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_d     = 1'b1;
        mem_write_raw = rdy;
        state_d       = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        alu_op_d    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 2'b01;
        branch      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut; ALU forms OldPC+4 for rd
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        pc_update   = 1'b1;
        state_d     = S_ALUWB;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Architectural strobes are killed while reset is held
  assign bus.pc_write   = ~reset & (pc_update | (branch & bus.zero));
  assign bus.ir_write   = ~reset & ir_write_raw;
  assign bus.mem_write  = ~reset & mem_write_raw;
  assign bus.reg_write  = ~reset & reg_write_raw;
  assign bus.adr_src    = adr_src_d;
  assign bus.result_src = result_src_d;
  assign bus.alu_src_a  = alu_src_a_d;
  assign bus.alu_src_b  = alu_src_b_d;
  assign bus.alu_op     = alu_op_d;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: per-cycle state, strobe and mux checks.
module tb_mc_main_fsm;

  logic clk;
  logic reset;
  logic sel;
  int   n_tests;
  int   n_fail;

  mc_main_fsm_if bus1 ();
  mc_main_fsm_if bus2 ();

  mc_main_fsm #(.USE_MEM_READY(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mc_main_fsm #(.USE_MEM_READY(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // {adr_src, result_src, alu_src_a, alu_src_b, alu_op} expected per state
  localparam logic [8:0] MUX_TBL [11] = '{
    9'b0_10_00_10_00,  // FETCH
    9'b0_00_01_01_00,  // DECODE
    9'b0_00_10_01_00,  // MEMADR
    9'b1_00_00_00_00,  // MEMREAD
    9'b0_01_00_00_00,  // MEMWB
    9'b1_00_00_00_00,  // MEMWRITE
    9'b0_00_10_00_10,  // EXECUTER
    9'b0_00_10_01_10,  // EXECUTEI
    9'b0_00_00_00_00,  // ALUWB
    9'b0_00_10_00_01,  // BEQ
    9'b0_00_01_10_00   // JAL
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic zero);
    bus1.op   = op;
    bus2.op   = op;
    bus1.zero = zero;
    bus2.zero = zero;
  endtask

  // Drive mem_ready, check the selected DUT in its current state, then advance one edge
  task automatic cyc(input string tag, input logic rdy, input logic [3:0] es, input logic [3:0] strb);
    logic [3:0] st;
    logic [3:0] sb;
    logic [8:0] mx;
    bus1.mem_ready = rdy;
    #1;
    if (sel) begin
      st = bus2.state;
      sb = {bus2.pc_write, bus2.ir_write, bus2.mem_write, bus2.reg_write};
      mx = {bus2.adr_src, bus2.result_src, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op};
    end else begin
      st = bus1.state;
      sb = {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write};
      mx = {bus1.adr_src, bus1.result_src, bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op};
    end
    check_eq({tag, ".state"}, 32'(st), 32'(es));
    check_eq({tag, ".strobes"}, 32'(sb), 32'(strb));
    check_eq({tag, ".mux"}, 32'(mx), 32'(MUX_TBL[es]));
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-flight; state and strobes must drop without a clock edge
  task automatic reset_pulse(input string tag);
    logic [3:0] st;
    logic [3:0] sb;
    reset = 1'b1;
    #1;
    if (sel) begin
      st = bus2.state;
      sb = {bus2.pc_write, bus2.ir_write, bus2.mem_write, bus2.reg_write};
    end else begin
      st = bus1.state;
      sb = {bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write};
    end
    check_eq({tag, ".state"}, 32'(st), 32'd0);
    check_eq({tag, ".strobes"}, 32'(sb), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sel     = 1'b0;
    reset   = 1'b1;
    bus1.mem_ready = 1'b1;
    bus2.mem_ready = 1'b0;
    set_in(7'b0110011, 1'b0);
    reset_pulse("por");

    // R-type: 0,1,6,8
    cyc("r0", 1'b1, 4'd0, 4'b1100);
    cyc("r1", 1'b1, 4'd1, 4'b0000);
    cyc("r2", 1'b1, 4'd6, 4'b0000);
    cyc("r3", 1'b1, 4'd8, 4'b0001);

    // I-type: 0,1,7,8
    set_in(7'b0010011, 1'b0);
    cyc("i0", 1'b1, 4'd0, 4'b1100);
    cyc("i1", 1'b1, 4'd1, 4'b0000);
    cyc("i2", 1'b1, 4'd7, 4'b0000);
    cyc("i3", 1'b1, 4'd8, 4'b0001);

    // lw with 3 FETCH waits and 2 MEMREAD waits: 10 cycles
    set_in(7'b0000011, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_fw", 1'b0, 4'd0, 4'b0000);
    cyc("lw0", 1'b1, 4'd0, 4'b1100);
    cyc("lw1", 1'b1, 4'd1, 4'b0000);
    cyc("lw2", 1'b1, 4'd2, 4'b0000);
    for (int i = 0; i < 2; i++) cyc("lw_mw", 1'b0, 4'd3, 4'b0000);
    cyc("lw3", 1'b1, 4'd3, 4'b0000);
    cyc("lw4", 1'b1, 4'd4, 4'b0001);

    // sw with one MEMWRITE wait: mem_write only once rdy
    set_in(7'b0100011, 1'b0);
    cyc("sw0", 1'b1, 4'd0, 4'b1100);
    cyc("sw1", 1'b1, 4'd1, 4'b0000);
    cyc("sw2", 1'b1, 4'd2, 4'b0000);
    cyc("sw_w", 1'b0, 4'd5, 4'b0000);
    cyc("sw3", 1'b1, 4'd5, 4'b0010);

    // beq taken and not taken
    set_in(7'b1100011, 1'b1);
    cyc("bt0", 1'b1, 4'd0, 4'b1100);
    cyc("bt1", 1'b1, 4'd1, 4'b0000);
    cyc("bt2", 1'b1, 4'd9, 4'b1000);
    set_in(7'b1100011, 1'b0);
    cyc("bn0", 1'b1, 4'd0, 4'b1100);
    cyc("bn1", 1'b1, 4'd1, 4'b0000);
    cyc("bn2", 1'b1, 4'd9, 4'b0000);

    // jal: 0,1,10,8
    set_in(7'b1101111, 1'b0);
    cyc("j0", 1'b1, 4'd0, 4'b1100);
    cyc("j1", 1'b1, 4'd1, 4'b0000);
    cyc("j2", 1'b1, 4'd10, 4'b1000);
    cyc("j3", 1'b1, 4'd8, 4'b0001);

    // unknown opcode: 0,1,0
    set_in(7'b0000000, 1'b0);
    cyc("n0", 1'b1, 4'd0, 4'b1100);
    cyc("n1", 1'b1, 4'd1, 4'b0000);

    // reset in EXECUTER, then resume from FETCH
    set_in(7'b0110011, 1'b0);
    cyc("x0", 1'b1, 4'd0, 4'b1100);
    cyc("x1", 1'b1, 4'd1, 4'b0000);
    reset_pulse("rst_exr");
    cyc("x2", 1'b1, 4'd0, 4'b1100);
    cyc("x3", 1'b1, 4'd1, 4'b0000);
    cyc("x4", 1'b1, 4'd6, 4'b0000);
    // reset in ALUWB must cancel the writeback
    reset_pulse("rst_wb");
    cyc("x5", 1'b1, 4'd0, 4'b1100);

    // USE_MEM_READY=0 instance with mem_ready held low: sw still 0,1,2,5,0
    sel = 1'b1;
    set_in(7'b0100011, 1'b0);
    reset_pulse("rst_nr");
    cyc("nr0", 1'b0, 4'd0, 4'b1100);
    cyc("nr1", 1'b0, 4'd1, 4'b0000);
    cyc("nr2", 1'b0, 4'd2, 4'b0000);
    cyc("nr3", 1'b0, 4'd5, 4'b0010);
    cyc("nr4", 1'b0, 4'd0, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
